// File: rtl/fpu_dispatch_arbiter_if.sv
// fpu_dispatch_arbiter_if
// Requester-side bus of the FPU dispatch arbiter: op requests going in, grants
// and tagged results coming back.
//
// Signals:
//   req_valid  [1:0]  per-requester op valid (bit i = requester i)
//   req_opcode [1:0]  per-requester opcode, 0 = add, 1 = mult
//   req_a      [63:0] operand A, requester i owns bits [32i+31:32i]
//   req_b      [63:0] operand B, same packing as req_a
//   req_ready  [1:0]  grant, at most one bit high
//   rsp_valid         result valid
//   rsp_id            requester the result belongs to
//   rsp_data   [31:0] result data (all ones when the unit failed to deliver)
//
// Modports: master = requester front-ends, slave = arbiter.
interface fpu_dispatch_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_opcode;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [1:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_id;
  logic [31:0] rsp_data;

  modport master (
    output req_valid, req_opcode, req_a, req_b,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_opcode, req_a, req_b,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/fpu_dispatch_arbiter.sv
// fpu_dispatch_arbiter
// Shares one adder and one multiplier between two requesters. Issues at most
// one op per cycle, books the writeback cycle of every issued op so the two
// units never complete together, and returns each result tagged with the id
// of the requester that issued it.
//
// Parameters:
//   ADD_LAT  adder latency, strobe sampled to adder_Data_Out_Valid (1..7)
//   MUL_LAT  multiplier latency, strobe sampled to mult_Data_Out_Valid (1..7)
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_bus (slave)               requests, grants and tagged results
//   add_In_Data_Valid/add_A/add_B adder issue strobe and operands (registered)
//   mult_In_Data_Valid/mult_A/B   multiplier issue strobe and operands
//   adder_Data_Out(_Valid)        adder result
//   mult_Data_Out(_Valid)         multiplier result
//   err                           sticky protocol-error flag
//
// Build option:
//   FPU_ARB_FIXED_PRIO_EN  when defined, requester 0 always wins when it is
//                          eligible and the round-robin pointer is removed.
module fpu_dispatch_arbiter #(
  parameter int ADD_LAT = 3,
  parameter int MUL_LAT = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  fpu_dispatch_arbiter_if.slave        req_bus,
  output logic                         add_In_Data_Valid,
  output logic [31:0]                  add_A,
  output logic [31:0]                  add_B,
  output logic                         mult_In_Data_Valid,
  output logic [31:0]                  mult_A,
  output logic [31:0]                  mult_B,
  input  logic [31:0]                  adder_Data_Out,
  input  logic                         adder_Data_Out_Valid,
  input  logic [31:0]                  mult_Data_Out,
  input  logic                         mult_Data_Out_Valid,
  output logic                         err
);

  localparam int MAX_LAT = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
  localparam int DEPTH   = MAX_LAT + 1;
  localparam int CW      = $clog2(DEPTH + 1);

  // Entry j describes the cycle j cycles from now; entry 0 is the current
  // cycle, so a completion is checked against entry 0.
  logic [DEPTH-1:0] res_q, res_op_q, res_tag_q;
  logic [DEPTH-1:0] res_sh, op_sh, tag_sh;
  logic [DEPTH-1:0] res_n, op_n, tag_n;
  logic [CW-1:0]    mask_cnt_q;

  logic [1:0]  elig;
  logic [1:0]  ready_c;
  logic        grant_any;
  logic        grant_id;
  logic        grant_op;
  logic [31:0] grant_a;
  logic [31:0] grant_b;

  logic        exp_valid;
  logic        other_valid;
  logic        err_event;
  logic [31:0] exp_data;

`ifndef FPU_ARB_FIXED_PRIO_EN
  logic rr_ptr_q;
`endif

  // The map as it will look next cycle. A request granted now returns in
  // cycle now+1+LAT, which is entry LAT of the shifted map; that is also the
  // slot its eligibility is tested against.
  assign res_sh = {1'b0, res_q[DEPTH-1:1]};
  assign op_sh  = {1'b0, res_op_q[DEPTH-1:1]};
  assign tag_sh = {1'b0, res_tag_q[DEPTH-1:1]};

  always_comb begin
    elig = '0;
    for (int i = 0; i < 2; i++) begin
      if (req_bus.req_opcode[i]) begin
        elig[i] = req_bus.req_valid[i] & ~res_sh[MUL_LAT] & ~rst;
      end else begin
        elig[i] = req_bus.req_valid[i] & ~res_sh[ADD_LAT] & ~rst;
      end
    end
  end

  // An ineligible requester never blocks the other one.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
`ifdef FPU_ARB_FIXED_PRIO_EN
    if (elig[0]) begin
      grant_any = 1'b1;
      grant_id  = 1'b0;
    end else if (elig[1]) begin
      grant_any = 1'b1;
      grant_id  = 1'b1;
    end
`else
    if (elig[rr_ptr_q]) begin
      grant_any = 1'b1;
      grant_id  = rr_ptr_q;
    end else if (elig[~rr_ptr_q]) begin
      grant_any = 1'b1;
      grant_id  = ~rr_ptr_q;
    end
`endif
    ready_c = 2'b00;
    if (grant_any) begin
      ready_c[grant_id] = 1'b1;
    end
  end

  assign req_bus.req_ready = ready_c;
  assign grant_op = req_bus.req_opcode[grant_id];
  assign grant_a  = grant_id ? req_bus.req_a[63:32] : req_bus.req_a[31:0];
  assign grant_b  = grant_id ? req_bus.req_b[63:32] : req_bus.req_b[31:0];

  always_comb begin
    res_n = res_sh;
    op_n  = op_sh;
    tag_n = tag_sh;
    if (grant_any) begin
      if (grant_op) begin
        res_n[MUL_LAT] = 1'b1;
        op_n[MUL_LAT]  = 1'b1;
        tag_n[MUL_LAT] = grant_id;
      end else begin
        res_n[ADD_LAT] = 1'b1;
        op_n[ADD_LAT]  = 1'b0;
        tag_n[ADD_LAT] = grant_id;
      end
    end
  end

  // Only the unit booked for this cycle may deliver. Anything else (the other
  // unit firing, a valid in an unbooked cycle, a booked unit staying silent,
  // or both units at once) is a protocol error.
  assign exp_valid   = res_q[0] & (res_op_q[0] ? mult_Data_Out_Valid : adder_Data_Out_Valid);
  assign other_valid = res_q[0] & (res_op_q[0] ? adder_Data_Out_Valid : mult_Data_Out_Valid);
  assign exp_data    = res_op_q[0] ? mult_Data_Out : adder_Data_Out;
  assign err_event   = (res_q[0] & ~exp_valid)
                     | other_valid
                     | (~res_q[0] & (adder_Data_Out_Valid | mult_Data_Out_Valid))
                     | (adder_Data_Out_Valid & mult_Data_Out_Valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      add_In_Data_Valid  <= 1'b0;
      add_A              <= '0;
      add_B              <= '0;
      mult_In_Data_Valid <= 1'b0;
      mult_A             <= '0;
      mult_B             <= '0;
      res_q              <= '0;
      res_op_q           <= '0;
      res_tag_q          <= '0;
      req_bus.rsp_valid  <= 1'b0;
      req_bus.rsp_id     <= 1'b0;
      req_bus.rsp_data   <= 32'hFFFF_FFFF;
      err                <= 1'b0;
      mask_cnt_q         <= CW'(DEPTH);
    end else begin
      add_In_Data_Valid  <= grant_any & ~grant_op;
      mult_In_Data_Valid <= grant_any & grant_op;
      if (grant_any & ~grant_op) begin
        add_A <= grant_a;
        add_B <= grant_b;
      end
      if (grant_any & grant_op) begin
        mult_A <= grant_a;
        mult_B <= grant_b;
      end

      res_q     <= res_n;
      res_op_q  <= op_n;
      res_tag_q <= tag_n;

      req_bus.rsp_valid <= res_q[0];
      if (res_q[0]) begin
        req_bus.rsp_id   <= res_tag_q[0];
        req_bus.rsp_data <= exp_valid ? exp_data : 32'hFFFF_FFFF;
      end

      // Results of ops dropped by a reset may still trickle out of the
      // units, so error detection stays off until they have drained.
      if (mask_cnt_q != '0) begin
        mask_cnt_q <= mask_cnt_q - CW'(1);
      end else if (err_event) begin
        err <= 1'b1;
      end
    end
  end

`ifndef FPU_ARB_FIXED_PRIO_EN
  // After a grant the other requester gets first pick.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= 1'b0;
    end else if (grant_any) begin
      rr_ptr_q <= ~grant_id;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_dispatch_arbiter.sv
// tb_fpu_dispatch_arbiter
// Self-checking bench for fpu_dispatch_arbiter with ADD_LAT=3, MUL_LAT=2.
// Contains simple registered adder/multiplier models with the configured
// latencies; the adder model can be told to swallow the valid of one issue.
// Honours FPU_ARB_FIXED_PRIO_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_fpu_dispatch_arbiter;
  localparam int ADD_LAT = 3;
  localparam int MUL_LAT = 2;
  localparam int FAIR_N  = 8;
  localparam int RAND_N  = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpu_dispatch_arbiter_if bus();

  logic        add_iv, mult_iv;
  logic [31:0] add_a_o, add_b_o, mult_a_o, mult_b_o;
  logic [31:0] add_out, mult_out;
  logic        add_ov, mult_ov;
  logic        err;
  logic        add_drop = 1'b0;

  int errors = 0;
  int checks = 0;

  fpu_dispatch_arbiter #(.ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .req_bus              (bus),
    .add_In_Data_Valid    (add_iv),
    .add_A                (add_a_o),
    .add_B                (add_b_o),
    .mult_In_Data_Valid   (mult_iv),
    .mult_A               (mult_a_o),
    .mult_B               (mult_b_o),
    .adder_Data_Out       (add_out),
    .adder_Data_Out_Valid (add_ov),
    .mult_Data_Out        (mult_out),
    .mult_Data_Out_Valid  (mult_ov),
    .err                  (err)
  );

  // Integer stand-ins for the FPU; 1.0+2.0 yields IEEE 3.0 for the directed case.
  function automatic logic [31:0] add_fn(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return a + b;
  endfunction

  function automatic logic [31:0] mul_fn(input logic [31:0] a, input logic [31:0] b);
    return a * b;
  endfunction

  // Unit models: the strobe is sampled at an edge and the result shows up
  // LAT cycles later. They are never reset, so in-flight work survives a DUT reset.
  logic [7:0]  add_vp = '0;
  logic [7:0]  mult_vp = '0;
  logic [31:0] add_dp [8];
  logic [31:0] mult_dp [8];

  always @(posedge clk) begin
    add_vp     <= {add_vp[6:0], add_iv & ~add_drop};
    mult_vp    <= {mult_vp[6:0], mult_iv};
    add_dp[0]  <= add_fn(add_a_o, add_b_o);
    mult_dp[0] <= mul_fn(mult_a_o, mult_b_o);
    for (int i = 1; i < 8; i++) begin
      add_dp[i]  <= add_dp[i-1];
      mult_dp[i] <= mult_dp[i-1];
    end
  end

  assign add_ov   = add_vp[ADD_LAT-1];
  assign add_out  = add_dp[ADD_LAT-1];
  assign mult_ov  = mult_vp[MUL_LAT-1];
  assign mult_out = mult_dp[MUL_LAT-1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] op,
                       input logic [31:0] a0, input logic [31:0] b0,
                       input logic [31:0] a1, input logic [31:0] b1);
    bus.req_valid  = v;
    bus.req_opcode = op;
    bus.req_a      = {a1, a0};
    bus.req_b      = {b1, b0};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(2'b00, 2'b00, '0, '0, '0, '0);
    step();
    step();
    rst = 1'b0;
    repeat (10) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(2'b11, 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom);
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (bus.req_ready !== 2'b00) begin errors++; $display("[TB] FAIL reset_ready cycle %0d got=%b exp=00", c, bus.req_ready); end
      checks++;
      if (add_iv !== 1'b0 || mult_iv !== 1'b0) begin errors++; $display("[TB] FAIL reset_strobes got=%b%b exp=00", add_iv, mult_iv); end
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp got v=%b id=%b exp 0/0", bus.rsp_valid, bus.rsp_id); end
      checks++;
      if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got=%b exp=0", err); end
      checks++;
      if (bus.rsp_data !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL reset_rsp_data got=%h exp=ffffffff", bus.rsp_data); end
      checks++;
      if ({add_a_o, add_b_o, mult_a_o, mult_b_o} !== 128'h0) begin errors++; $display("[TB] FAIL reset_operands not zero"); end
    end
    rst = 1'b0;
    drive(2'b00, 2'b00, '0, '0, '0, '0);
    repeat (10) step();
  endtask

  task automatic test_single_add();
    logic [1:0] er;
    do_reset();
    for (int t = 0; t < 8; t++) begin
      if (t == 0) drive(2'b01, 2'b00, 32'h3F80_0000, 32'h4000_0000, '0, '0);
      else        drive(2'b00, 2'b00, '0, '0, '0, '0);
      #1;
      er = (t == 0) ? 2'b01 : 2'b00;
      checks++;
      if (bus.req_ready !== er) begin errors++; $display("[TB] FAIL add_ready t=%0d got=%b exp=%b", t, bus.req_ready, er); end
      checks++;
      if (add_iv !== (t == 1) || mult_iv !== 1'b0) begin errors++; $display("[TB] FAIL add_strobe t=%0d got=%b%b", t, add_iv, mult_iv); end
      if (t == 1) begin
        checks++;
        if (add_a_o !== 32'h3F80_0000 || add_b_o !== 32'h4000_0000) begin errors++; $display("[TB] FAIL add_operands got=%h/%h", add_a_o, add_b_o); end
      end
      checks++;
      if (bus.rsp_valid !== (t == 5)) begin errors++; $display("[TB] FAIL add_rsp_valid t=%0d got=%b", t, bus.rsp_valid); end
      if (t == 5) begin
        checks++;
        if (bus.rsp_id !== 1'b0 || bus.rsp_data !== 32'h4040_0000) begin errors++; $display("[TB] FAIL add_rsp got id=%b data=%h exp 0/40400000", bus.rsp_id, bus.rsp_data); end
      end
      step();
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("[TB] FAIL add_err got=%b exp=0", err); end
  endtask

  task automatic test_fairness();
    logic [31:0] ca [2];
    logic [31:0] cb [2];
    logic [31:0] ed [FAIR_N];
    bit          eid [FAIR_N];
    int          eg;
    logic [1:0]  er;
    do_reset();
    for (int i = 0; i < 2; i++) begin ca[i] = $urandom; cb[i] = $urandom; end
    for (int t = 0; t < FAIR_N + 6; t++) begin
      drive((t < FAIR_N) ? 2'b11 : 2'b00, 2'b11, ca[0], cb[0], ca[1], cb[1]);
      #1;
`ifdef FPU_ARB_FIXED_PRIO_EN
      eg = 0;
`else
      eg = t % 2;
`endif
      er = (t < FAIR_N) ? ((eg == 0) ? 2'b01 : 2'b10) : 2'b00;
      checks++;
      if (bus.req_ready !== er) begin errors++; $display("[TB] FAIL fair_ready t=%0d got=%b exp=%b", t, bus.req_ready, er); end
      if (t < FAIR_N) begin
        ed[t]  = mul_fn(ca[eg], cb[eg]);
        eid[t] = (eg == 1);
      end
      checks++;
      if (t >= 4 && t - 4 < FAIR_N) begin
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== eid[t-4] || bus.rsp_data !== ed[t-4]) begin
          errors++;
          $display("[TB] FAIL fair_rsp t=%0d got v=%b id=%b data=%h exp 1/%b/%h", t, bus.rsp_valid, bus.rsp_id, bus.rsp_data, eid[t-4], ed[t-4]);
        end
      end else if (bus.rsp_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL fair_rsp_idle t=%0d got=%b exp=0", t, bus.rsp_valid);
      end
      step();
      if (t < FAIR_N) begin ca[eg] = $urandom; cb[eg] = $urandom; end
    end
  endtask

  task automatic test_hazard();
    logic [31:0] a0, b0, a1, b1;
    logic [1:0]  er;
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    do_reset();
    for (int t = 0; t < 9; t++) begin
      case (t)
        0:       drive(2'b01, 2'b00, a0, b0, '0, '0);
        1, 2:    drive(2'b10, 2'b10, '0, '0, a1, b1);
        default: drive(2'b00, 2'b00, '0, '0, '0, '0);
      endcase
      #1;
      er = (t == 0) ? 2'b01 : (t == 2) ? 2'b10 : 2'b00;
      checks++;
      if (bus.req_ready !== er) begin errors++; $display("[TB] FAIL hazard_ready t=%0d got=%b exp=%b", t, bus.req_ready, er); end
      checks++;
      if (add_iv !== (t == 1) || mult_iv !== (t == 3)) begin errors++; $display("[TB] FAIL hazard_strobe t=%0d got add=%b mult=%b", t, add_iv, mult_iv); end
      checks++;
      if (t == 5) begin
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_data !== add_fn(a0, b0)) begin errors++; $display("[TB] FAIL hazard_rsp_add got v=%b id=%b data=%h", bus.rsp_valid, bus.rsp_id, bus.rsp_data); end
      end else if (t == 6) begin
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1 || bus.rsp_data !== mul_fn(a1, b1)) begin errors++; $display("[TB] FAIL hazard_rsp_mult got v=%b id=%b data=%h", bus.rsp_valid, bus.rsp_id, bus.rsp_data); end
      end else if (bus.rsp_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL hazard_rsp_idle t=%0d got=%b exp=0", t, bus.rsp_valid);
      end
      step();
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("[TB] FAIL hazard_err got=%b exp=0", err); end
  endtask

  task automatic test_missing_result();
    do_reset();
    add_drop = 1'b1;
    for (int t = 0; t < 10; t++) begin
      if (t == 0) drive(2'b01, 2'b00, $urandom, $urandom, '0, '0);
      else        drive(2'b00, 2'b00, '0, '0, '0, '0);
      if (t == 2) add_drop = 1'b0;
      #1;
      checks++;
      if (bus.rsp_valid !== (t == 5)) begin errors++; $display("[TB] FAIL miss_rsp_valid t=%0d got=%b", t, bus.rsp_valid); end
      if (t == 5) begin
        checks++;
        if (bus.rsp_id !== 1'b0 || bus.rsp_data !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL miss_rsp got id=%b data=%h exp 0/ffffffff", bus.rsp_id, bus.rsp_data); end
      end
      checks++;
      if (err !== (t >= 5)) begin errors++; $display("[TB] FAIL miss_err t=%0d got=%b exp=%b", t, err, (t >= 5)); end
      step();
    end
    do_reset();
    checks++;
    if (err !== 1'b0) begin errors++; $display("[TB] FAIL miss_err_cleared got=%b exp=0", err); end
  endtask

  task automatic test_reset_midflight();
    logic [1:0] er;
    do_reset();
    for (int t = 0; t < 13; t++) begin
      rst = (t == 2);
      case (t)
        0:       drive(2'b10, 2'b10, '0, '0, $urandom, $urandom);
        1:       drive(2'b01, 2'b00, $urandom, $urandom, '0, '0);
        default: drive(2'b00, 2'b00, '0, '0, '0, '0);
      endcase
      #1;
      er = (t == 0) ? 2'b10 : (t == 1) ? 2'b01 : 2'b00;
      checks++;
      if (bus.req_ready !== er) begin errors++; $display("[TB] FAIL midrst_ready t=%0d got=%b exp=%b", t, bus.req_ready, er); end
      if (t >= 3) begin
        checks++;
        if (bus.rsp_valid !== 1'b0 || err !== 1'b0) begin errors++; $display("[TB] FAIL midrst_quiet t=%0d got rsp_valid=%b err=%b exp 0/0", t, bus.rsp_valid, err); end
      end
      step();
    end
    rst = 1'b0;
  endtask

  // Reference: a calendar of booked response cycles. A request is granted
  // when its response cycle is free, preferring whoever did not win last.
  task automatic test_random();
    bit          pend [2];
    bit          op [2];
    logic [31:0] ra [2];
    logic [31:0] rb [2];
    bit          el [2];
    bit          slot_v [int];
    bit          slot_id [int];
    logic [31:0] slot_d [int];
    logic [63:0] add_ops [int];
    logic [63:0] mult_ops [int];
    int          g, lat;
    logic [1:0]  er;
`ifndef FPU_ARB_FIXED_PRIO_EN
    int          pref = 0;
`endif
    do_reset();
    for (int i = 0; i < 2; i++) begin pend[i] = 0; op[i] = 0; ra[i] = '0; rb[i] = '0; end
    for (int t = 0; t < RAND_N + 10; t++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && t < RAND_N && $urandom_range(0, 1) == 1) begin
          pend[i] = 1;
          op[i]   = ($urandom_range(0, 1) == 1);
          ra[i]   = $urandom;
          rb[i]   = $urandom;
        end
      end
      drive({pend[1], pend[0]}, {op[1], op[0]}, ra[0], rb[0], ra[1], rb[1]);
      #1;
      for (int i = 0; i < 2; i++) begin
        lat   = op[i] ? MUL_LAT : ADD_LAT;
        el[i] = pend[i] && !slot_v.exists(t + 2 + lat);
      end
      g = -1;
`ifdef FPU_ARB_FIXED_PRIO_EN
      if (el[0]) g = 0;
      else if (el[1]) g = 1;
`else
      if (el[pref]) g = pref;
      else if (el[1-pref]) g = 1 - pref;
`endif
      er = (g < 0) ? 2'b00 : (g == 0) ? 2'b01 : 2'b10;
      checks++;
      if (bus.req_ready !== er) begin errors++; $display("[TB] FAIL rand_ready t=%0d got=%b exp=%b", t, bus.req_ready, er); end
      checks++;
      if (add_iv !== add_ops.exists(t) || mult_iv !== mult_ops.exists(t)) begin errors++; $display("[TB] FAIL rand_strobe t=%0d got add=%b mult=%b", t, add_iv, mult_iv); end
      if (add_ops.exists(t)) begin
        checks++;
        if ({add_a_o, add_b_o} !== add_ops[t]) begin errors++; $display("[TB] FAIL rand_add_ops t=%0d got=%h exp=%h", t, {add_a_o, add_b_o}, add_ops[t]); end
      end
      if (mult_ops.exists(t)) begin
        checks++;
        if ({mult_a_o, mult_b_o} !== mult_ops[t]) begin errors++; $display("[TB] FAIL rand_mult_ops t=%0d got=%h exp=%h", t, {mult_a_o, mult_b_o}, mult_ops[t]); end
      end
      checks++;
      if (slot_v.exists(t)) begin
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== slot_id[t] || bus.rsp_data !== slot_d[t]) begin
          errors++;
          $display("[TB] FAIL rand_rsp t=%0d got v=%b id=%b data=%h exp 1/%b/%h", t, bus.rsp_valid, bus.rsp_id, bus.rsp_data, slot_id[t], slot_d[t]);
        end
      end else if (bus.rsp_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL rand_rsp_idle t=%0d got=%b exp=0", t, bus.rsp_valid);
      end
      checks++;
      if (err !== 1'b0) begin errors++; $display("[TB] FAIL rand_err t=%0d got=%b exp=0", t, err); end
      if (g >= 0) begin
        lat = op[g] ? MUL_LAT : ADD_LAT;
        slot_v[t + 2 + lat]  = 1;
        slot_id[t + 2 + lat] = (g == 1);
        slot_d[t + 2 + lat]  = op[g] ? mul_fn(ra[g], rb[g]) : add_fn(ra[g], rb[g]);
        if (op[g]) mult_ops[t + 1] = {ra[g], rb[g]};
        else       add_ops[t + 1]  = {ra[g], rb[g]};
`ifndef FPU_ARB_FIXED_PRIO_EN
        pref = 1 - g;
`endif
      end
      step();
      if (g >= 0) pend[g] = 0;
    end
  endtask

  initial begin
    drive(2'b00, 2'b00, '0, '0, '0, '0);
    test_reset();
    test_single_add();
    test_fairness();
    test_hazard();
    test_missing_result();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
